// File: rtl/filter_pkg.sv
// Shared encodings for the filter load sequencer, im_filter and benches.
package filter_pkg;

  typedef logic [2:0] fl_state_t;

  localparam fl_state_t ST_IDLE    = 3'd0;
  localparam fl_state_t ST_LOAD_CF = 3'd1;
  localparam fl_state_t ST_GAP     = 3'd2;
  localparam fl_state_t ST_STREAM  = 3'd3;
  localparam fl_state_t ST_DRAIN   = 3'd4;
  localparam fl_state_t ST_DONE    = 3'd5;

  localparam logic DATA_ID_CF  = 1'b1;
  localparam logic DATA_ID_PIX = 1'b0;

  function automatic logic is_busy_state(input fl_state_t s);
    return (s == ST_LOAD_CF) || (s == ST_GAP) || (s == ST_STREAM) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/filter_load_ctrl_fl_counter.sv
// Up-counter with clear/load/increment and an equality terminal-count flag.
module fl_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/filter_load_ctrl.sv
// Sequencer in front of im_filter: coefficient load, idle gap, pixel frame, output drain.
// state   | meaning
// IDLE    | wait for start      LOAD_CF | accept NCF coefs    GAP  | GAP_CYC idle cycles
// STREAM  | accept R*C pixels   DRAIN   | await filter output DONE | one-cycle done pulse
module filter_load_ctrl
  import filter_pkg::*;
#(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1,
  parameter int ROW_WIDTH  = 10,
  parameter int COL_WIDTH  = 10,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 9,
  parameter int GAP_CYC    = 20,
  parameter int TMO_BIT    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cf_valid,
  input  logic [DATA_BIT-1:0]   cf_data,
  output logic                  cf_ready,
  input  logic                  px_valid,
  input  logic [DATA_BIT-1:0]   px_data,
  output logic                  px_ready,
  output logic                  data_in_valid,
  output logic [DATA_BIT-1:0]   data_in,
  output logic [DATA_IDBIT-1:0] data_id,
  input  logic                  pix_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_tmo
);

  localparam int NCF  = MASK_WIDTH * MASK_WIDTH;
  localparam int NPIX = ROW_WIDTH * COL_WIDTH;

  localparam logic [CNT_BIT-1:0] NCF_LAST  = CNT_BIT'(NCF - 1);
  localparam logic [CNT_BIT-1:0] NPIX_LAST = CNT_BIT'(NPIX - 1);
  localparam logic [CNT_BIT-1:0] NPIX_ALL  = CNT_BIT'(NPIX);
  localparam logic [CNT_BIT-1:0] GAP_LAST  = CNT_BIT'(GAP_CYC - 1);
  // Firing on the last silent cycle makes 2**TMO_BIT-1 silent cycles in total.
  localparam logic [TMO_BIT-1:0] TMO_LAST  = TMO_BIT'((2 ** TMO_BIT) - 2);

  fl_state_t state_q, state_d;

  logic               cf_acc, px_acc, word_acc;
  logic               in_clr, in_last;
  logic [CNT_BIT-1:0] in_cnt, in_tc_val;
  logic               in_tc;
  logic               gap_clr, gap_inc, gap_tc;
  logic [CNT_BIT-1:0] gap_cnt;
  logic               out_clr, out_inc, out_tc, out_full;
  logic [CNT_BIT-1:0] out_cnt;
  logic               wd_clr, wd_inc, wd_tc, tmo_hit;
  logic [TMO_BIT-1:0] wd_cnt;
  logic               start_ok;

  assign cf_ready = (state_q == ST_LOAD_CF);
  assign px_ready = (state_q == ST_STREAM);
  assign busy     = is_busy_state(state_q);
  assign done     = (state_q == ST_DONE);

  assign cf_acc   = cf_valid & cf_ready;
  assign px_acc   = px_valid & px_ready;
  assign word_acc = cf_acc | px_acc;
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Input word counter is shared by the coefficient and pixel phases.
  assign in_tc_val = (state_q == ST_STREAM) ? NPIX_LAST : NCF_LAST;
  assign in_last   = word_acc & in_tc;
  assign in_clr    = abort | in_last | ~((state_q == ST_LOAD_CF) | (state_q == ST_STREAM));

  fl_counter #(.W(CNT_BIT)) u_in_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (in_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (word_acc),
    .tc_val   (in_tc_val),
    .cnt      (in_cnt),
    .tc       (in_tc)
  );

  assign gap_inc = (state_q == ST_GAP);
  assign gap_clr = abort | ~gap_inc | gap_tc;

  fl_counter #(.W(CNT_BIT)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (gap_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (gap_inc),
    .tc_val   (GAP_LAST),
    .cnt      (gap_cnt),
    .tc       (gap_tc)
  );

  // The filter may start emitting while pixels are still going in.
  assign out_inc  = pix_out_valid & ((state_q == ST_STREAM) | (state_q == ST_DRAIN));
  assign out_clr  = abort | ~((state_q == ST_STREAM) | (state_q == ST_DRAIN));
  assign out_full = (out_cnt == NPIX_ALL) | (out_inc & out_tc);

  fl_counter #(.W(CNT_BIT)) u_out_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (out_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (out_inc),
    .tc_val   (NPIX_LAST),
    .cnt      (out_cnt),
    .tc       (out_tc)
  );

  assign wd_inc  = (state_q == ST_DRAIN);
  assign wd_clr  = abort | ~wd_inc | pix_out_valid;
  assign tmo_hit = wd_inc & ~pix_out_valid & wd_tc;

  fl_counter #(.W(TMO_BIT)) u_wd_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (wd_inc),
    .tc_val   (TMO_LAST),
    .cnt      (wd_cnt),
    .tc       (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD_CF;
      ST_LOAD_CF: if (cf_acc && in_tc) state_d = ST_GAP;
      ST_GAP:     if (gap_tc) state_d = ST_STREAM;
      ST_STREAM:  if (px_acc && in_tc) state_d = out_full ? ST_DONE : ST_DRAIN;
      ST_DRAIN:   if (out_full || tmo_hit) state_d = ST_DONE;
      ST_DONE:    state_d = start ? ST_LOAD_CF : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      data_in_valid <= 1'b0;
      data_in       <= '0;
      data_id       <= '0;
      err_tmo       <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_in_valid <= 1'b0;
      if (!abort && cf_acc) begin
        data_in_valid <= 1'b1;
        data_in       <= cf_data;
        data_id       <= DATA_IDBIT'(DATA_ID_CF);
      end else if (!abort && px_acc) begin
        data_in_valid <= 1'b1;
        data_in       <= px_data;
        data_id       <= DATA_IDBIT'(DATA_ID_PIX);
      end
      if (start_ok && !abort) begin
        err_tmo <= 1'b0;
      end else if (tmo_hit && !abort) begin
        err_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl with a source driver and a simple im_filter output model.
module tb_filter_load_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cf_valid = 1'b0;
  logic [14:0] cf_data = '0;
  logic        cf_ready;
  logic        px_valid = 1'b0;
  logic [14:0] px_data = '0;
  logic        px_ready;
  logic        data_in_valid;
  logic [14:0] data_in;
  logic [0:0]  data_id;
  logic        pix_out_valid = 1'b0;
  logic        busy, done, err_tmo;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cf_idx = 0, px_idx = 0, n_out = 0, out_lim = 100;
  bit bp = 1'b0, tog = 1'b0, cf_hs = 1'b0, px_hs = 1'b0;
  int last_po_cyc = -1, done_cnt = 0, done_cyc = -1;
  logic [0:0]  log_id[$];
  logic [14:0] log_dat[$];
  int          log_cyc[$];

  filter_load_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cf_valid      (cf_valid),
    .cf_data       (cf_data),
    .cf_ready      (cf_ready),
    .px_valid      (px_valid),
    .px_data       (px_data),
    .px_ready      (px_ready),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .data_id       (data_id),
    .pix_out_valid (pix_out_valid),
    .busy          (busy),
    .done          (done),
    .err_tmo       (err_tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sources, filter output model and word log, all on the falling edge.
  always @(negedge clk) begin
    if (cf_hs) cf_idx++;
    if (px_hs) px_idx++;
    tog = ~tog;
    cf_valid = (cf_idx < 49) && (!bp || tog);
    cf_data  = 15'd334;
    px_valid = (px_idx < 100) && (!bp || tog);
    px_data  = 15'(px_idx + 1);
    cf_hs = cf_valid && cf_ready;
    px_hs = px_valid && px_ready;
    pix_out_valid = data_in_valid && (data_id == 1'b0) && (n_out < out_lim);
    if (pix_out_valid) begin
      n_out++;
      last_po_cyc = cyc;
    end
    if (data_in_valid) begin
      log_id.push_back(data_id);
      log_dat.push_back(data_in);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic int seq_errors();
    int e = 0;
    for (int i = 0; i < log_dat.size(); i++) begin
      if (i < 49) begin
        if (log_id[i] !== 1'b1 || log_dat[i] !== 15'd334) e++;
      end else begin
        if (log_id[i] !== 1'b0 || log_dat[i] !== 15'(i - 48)) e++;
      end
    end
    return e;
  endfunction

  task automatic arm(input bit bpi, input int lim);
    cf_idx = 0; px_idx = 0; cf_hs = 1'b0; px_hs = 1'b0;
    n_out = 0; out_lim = lim; bp = bpi;
    log_id.delete(); log_dat.delete(); log_cyc.delete();
    done_cnt = 0; done_cyc = -1; last_po_cyc = -1;
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1 start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if ({cf_ready, px_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {cf_ready, px_ready}); end
    n_checks++; if (data_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_in_valid); end
    n_checks++; if ({data_id, data_in} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", {data_id, data_in}); end
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_err_tmo: got %b want 0", err_tmo); end
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    int s0;
    arm(1'b0, 100);
    pulse_start(s0);
    n_checks++; if ({busy, cf_ready} !== 2'b11) begin n_fail++; $display("FAIL nom_load_entry: busy,cf_ready got %b want 11", {busy, cf_ready}); end
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (log_dat.size() !== 149) begin n_fail++; $display("FAIL nom_word_count: got %0d want 149", log_dat.size()); end
    n_checks++; if (seq_errors() !== 0) begin n_fail++; $display("FAIL nom_sequence: got %0d bad words want 0", seq_errors()); end
    n_checks++; if (log_cyc[0] - s0 !== 2) begin n_fail++; $display("FAIL nom_first_coef_lat: got %0d want 2", log_cyc[0] - s0); end
    n_checks++; if (log_cyc[49] - log_cyc[48] - 1 !== 20) begin n_fail++; $display("FAIL nom_gap: got %0d idle cycles want 20", log_cyc[49] - log_cyc[48] - 1); end
    n_checks++; if (done_cyc - s0 !== 171) begin n_fail++; $display("FAIL nom_done_time: got %0d want 171", done_cyc - s0); end
    n_checks++; if (done_cyc - last_po_cyc !== 1) begin n_fail++; $display("FAIL nom_done_after_last: got %0d want 1", done_cyc - last_po_cyc); end
    n_checks++; if ({busy, err_tmo} !== 2'b00) begin n_fail++; $display("FAIL nom_end_state: busy,err_tmo got %b want 00", {busy, err_tmo}); end
  endtask

  task automatic test_backpressure();
    int s0;
    arm(1'b1, 100);
    pulse_start(s0);
    for (int i = 0; i < 800 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (log_dat.size() !== 149) begin n_fail++; $display("FAIL bp_word_count: got %0d want 149", log_dat.size()); end
    n_checks++; if (seq_errors() !== 0) begin n_fail++; $display("FAIL bp_sequence: got %0d bad words want 0", seq_errors()); end
    n_checks++; if (log_cyc[48] - log_cyc[0] !== 96) begin n_fail++; $display("FAIL bp_coef_span: got %0d want 96", log_cyc[48] - log_cyc[0]); end
    n_checks++; if (log_cyc[148] - log_cyc[49] !== 198) begin n_fail++; $display("FAIL bp_pix_span: got %0d want 198", log_cyc[148] - log_cyc[49]); end
    n_checks++; if (done_cyc - last_po_cyc !== 1) begin n_fail++; $display("FAIL bp_done_after_last: got %0d want 1", done_cyc - last_po_cyc); end
  endtask

  task automatic test_start_busy();
    int s0, s1;
    arm(1'b0, 100);
    pulse_start(s0);
    for (int i = 0; i < 300 && px_idx < 50; i++) @(posedge clk);
    pulse_start(s1);
    n_checks++; if ({busy, px_ready} !== 2'b11) begin n_fail++; $display("FAIL busy_start_ignored: busy,px_ready got %b want 11", {busy, px_ready}); end
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (log_dat.size() !== 149) begin n_fail++; $display("FAIL busy_word_count: got %0d want 149", log_dat.size()); end
    n_checks++; if (seq_errors() !== 0) begin n_fail++; $display("FAIL busy_sequence: got %0d bad words want 0", seq_errors()); end
    n_checks++; if (done_cyc - s0 !== 171) begin n_fail++; $display("FAIL busy_done_time: got %0d want 171", done_cyc - s0); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int s0;
    arm(1'b0, 100);
    pulse_start(s0);
    for (int i = 0; i < 300 && px_idx < 40; i++) @(posedge clk);
    n_checks++; if ((px_idx >= 40) !== 1'b1) begin n_fail++; $display("FAIL rst_reach_pix40: got px_idx %0d want 40", px_idx); end
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    n_checks++; if ({busy, done, cf_ready, px_ready, data_in_valid} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 00000", {busy, done, cf_ready, px_ready, data_in_valid}); end
    n_checks++; if ({data_id, data_in} !== 16'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0000", {data_id, data_in}); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stays_idle: busy got %b want 0", busy); end
    arm(1'b0, 100);
    pulse_start(s0);
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (log_dat.size() !== 149) begin n_fail++; $display("FAIL rst_replay_count: got %0d want 149", log_dat.size()); end
    n_checks++; if (seq_errors() !== 0) begin n_fail++; $display("FAIL rst_replay_sequence: got %0d bad words want 0", seq_errors()); end
    n_checks++; if (done_cyc - s0 !== 171) begin n_fail++; $display("FAIL rst_replay_done_time: got %0d want 171", done_cyc - s0); end
  endtask

  task automatic test_timeout();
    int s0;
    arm(1'b0, 99);
    pulse_start(s0);
    repeat (700) @(posedge clk);
    #1;
    n_checks++; if ({busy, err_tmo} !== 2'b10) begin n_fail++; $display("FAIL tmo_draining: busy,err_tmo got %b want 10", {busy, err_tmo}); end
    for (int i = 0; i < 1000 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL tmo_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc - last_po_cyc !== 1024) begin n_fail++; $display("FAIL tmo_done_time: got %0d want 1024", done_cyc - last_po_cyc); end
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1", err_tmo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: busy got %b want 0", busy); end
    arm(1'b0, 100);
    pulse_start(s0);
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err_tmo); end
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic test_abort_gap();
    int s0;
    int npix;
    arm(1'b0, 100);
    pulse_start(s0);
    for (int i = 0; i < 200 && cf_idx < 49; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_checks++; if ({busy, cf_ready, px_ready, data_in_valid} !== 4'b0) begin n_fail++; $display("FAIL abort_outputs: got %b want 0000", {busy, cf_ready, px_ready, data_in_valid}); end
    repeat (150) @(posedge clk);
    #1;
    npix = 0;
    foreach (log_id[i]) if (log_id[i] === 1'b0) npix++;
    n_checks++; if (npix !== 0) begin n_fail++; $display("FAIL abort_no_pixels: got %0d pixel words want 0", npix); end
    n_checks++; if (log_dat.size() !== 49) begin n_fail++; $display("FAIL abort_coef_count: got %0d want 49", log_dat.size()); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_timeout();
    test_abort_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
